// File: rtl/axi_lite_timestable_slave.sv
// AXI4-lite responder holding the 8x8 times table (64 x 32-bit words).
// The table is rebuilt one entry per cycle after every reset; single-beat reads and writes only.
module axi_lite_timestable_slave #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              init_done
);

  localparam int unsigned Depth = 2 ** IDX_W;
  localparam int unsigned HalfW = IDX_W / 2;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic {StInit, StDone} init_state_e;
  typedef enum logic [1:0] {RIdle, RRead, RResp} rd_state_e;
  typedef enum logic [1:0] {WIdle, WCommit, WResp} wr_state_e;

  logic [DATA_W-1:0] mem_q [Depth];

  // ---------------------------------------------------------------------------
  // Init FSM
  // ---------------------------------------------------------------------------
  init_state_e      init_state_q, init_state_d;
  logic [IDX_W-1:0] init_idx_q;
  logic             init_we;
  logic [IDX_W-1:0] init_a, init_b, init_prod;
  logic [DATA_W-1:0] init_word;

  always_ff @(posedge clk) begin
    if (rst) init_state_q <= StInit;
    else     init_state_q <= init_state_d;
  end

  always_comb begin
    init_state_d = init_state_q;
    unique case (init_state_q)
      StInit:  if (init_idx_q == IDX_W'(Depth - 1)) init_state_d = StDone;
      StDone:  init_state_d = StDone;
      default: init_state_d = StInit;
    endcase
  end

  always_comb begin
    init_done = 1'b0;
    init_we   = 1'b0;
    unique case (init_state_q)
      StInit:  init_we   = !rst;
      StDone:  init_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)          init_idx_q <= '0;
    else if (init_we) init_idx_q <= init_idx_q + 1'b1;
  end

  // Index is {a, b}; the product of the two halves always fits in IDX_W bits.
  assign init_a    = {{(IDX_W - HalfW){1'b0}}, init_idx_q[IDX_W-1:HalfW]};
  assign init_b    = {{(IDX_W - HalfW){1'b0}}, init_idx_q[HalfW-1:0]};
  assign init_prod = init_a * init_b;
  assign init_word = {{(DATA_W - IDX_W){1'b0}}, init_prod};

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  rd_state_e         r_state_q, r_state_d;
  logic [ADDR_W-1:0] araddr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              ar_fire, r_hit;
  logic [IDX_W-1:0]  r_idx;

  assign ar_fire = s_axi_arvalid && s_axi_arready;
  assign r_hit   = (araddr_q[ADDR_W-1:IDX_W] == '0);
  assign r_idx   = araddr_q[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) r_state_q <= RIdle;
    else     r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      RIdle:   if (ar_fire) r_state_d = RRead;
      RRead:   r_state_d = RResp;
      RResp:   if (s_axi_rready) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  always_comb begin
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    unique case (r_state_q)
      RIdle:   s_axi_arready = init_done;
      RRead:   ;
      RResp:   s_axi_rvalid  = 1'b1;
      default: ;
    endcase
  end

  // mem_q is sampled before any same-cycle commit lands, so a collision returns old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      araddr_q <= '0;
      rdata_q  <= '0;
      rresp_q  <= RespOkay;
    end else begin
      if (ar_fire) araddr_q <= s_axi_araddr;
      if (r_state_q == RRead) begin
        rdata_q <= r_hit ? mem_q[r_idx] : '0;
        rresp_q <= r_hit ? RespOkay : RespSlverr;
      end
    end
  end

  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  wr_state_e         w_state_q, w_state_d;
  logic              aw_held_q, w_held_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic [1:0]        bresp_q;
  logic              aw_fire, w_fire, b_fire, w_hit, mem_we;
  logic [IDX_W-1:0]  w_idx;

  assign aw_fire = s_axi_awvalid && s_axi_awready;
  assign w_fire  = s_axi_wvalid && s_axi_wready;
  assign b_fire  = s_axi_bvalid && s_axi_bready;
  assign w_hit   = (awaddr_q[ADDR_W-1:IDX_W] == '0);
  assign w_idx   = awaddr_q[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) w_state_q <= WIdle;
    else     w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      WIdle:   if ((aw_held_q || aw_fire) && (w_held_q || w_fire)) w_state_d = WCommit;
      WCommit: w_state_d = WResp;
      WResp:   if (s_axi_bready) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    mem_we        = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        s_axi_awready = init_done && !aw_held_q;
        s_axi_wready  = init_done && !w_held_q;
      end
      WCommit: mem_we       = w_hit;
      WResp:   s_axi_bvalid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RespOkay;
    end else begin
      if (b_fire) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end else begin
        if (aw_fire) begin
          aw_held_q <= 1'b1;
          awaddr_q  <= s_axi_awaddr;
        end
        if (w_fire) begin
          w_held_q <= 1'b1;
          wdata_q  <= s_axi_wdata;
          wstrb_q  <= s_axi_wstrb;
        end
      end
      if (w_state_q == WCommit) bresp_q <= w_hit ? RespOkay : RespSlverr;
    end
  end

  assign s_axi_bresp = bresp_q;

  // ---------------------------------------------------------------------------
  // Table storage; init and commit never overlap since commits need init_done.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem_q[init_idx_q] <= init_word;
    end else if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (wstrb_q[k]) mem_q[w_idx][8*k +: 8] <= wdata_q[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_timestable_slave.sv
// Directed bench for axi_lite_timestable_slave: read vector table, full table sweep,
// and hand-written sequences for split handshakes, back-pressure and mid-read reset.
module tb_axi_lite_timestable_slave;

  logic        clk;
  logic        rst;
  logic [31:0] s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [31:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        init_done;

  axi_lite_timestable_slave #(
    .DATA_W(32),
    .ADDR_W(32),
    .IDX_W (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .init_done    (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // Full read; hs_ok covers arready low until the R handshake and high right after it.
  task automatic do_read(input logic [31:0] addr, input int stall, output logic [31:0] data,
                         output logic [1:0] resp, output int lat, output logic hs_ok,
                         output logic stable_ok);
    int n;
    hs_ok = 1'b1; stable_ok = 1'b1; lat = 0; data = '0; resp = '0;
    @(negedge clk);
    s_axi_araddr = addr;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 100) begin @(negedge clk); n++; end
    if (!s_axi_arready) begin
      s_axi_arvalid = 1'b0;
      timeout("ar_handshake");
      return;
    end
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    if (s_axi_arready) hs_ok = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin
      @(posedge clk); #1; n++;
      if (s_axi_arready) hs_ok = 1'b0;
    end
    lat = n;
    if (!s_axi_rvalid) begin timeout("rvalid"); return; end
    data = s_axi_rdata;
    resp = s_axi_rresp;
    repeat (stall) begin
      @(posedge clk); #1;
      if (!s_axi_rvalid || s_axi_rdata !== data || s_axi_rresp !== resp || s_axi_arready)
        stable_ok = 1'b0;
    end
    s_axi_rready = 1'b1;
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
    if (!s_axi_arready || s_axi_rvalid) hs_ok = 1'b0;
  endtask

  // Full write; AW and W are presented aw_dly / w_dly cycles after the start.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input int stall, output logic [1:0] resp, output logic stable_ok);
    logic aw_done, w_done, aw_go, w_go;
    int   n;
    aw_done = 1'b0; w_done = 1'b0; stable_ok = 1'b1; resp = 2'b11;
    s_axi_awaddr = addr;
    s_axi_wdata  = data;
    s_axi_wstrb  = strb;
    for (int cyc = 0; cyc < 100 && !(aw_done && w_done); cyc++) begin
      @(negedge clk);
      s_axi_awvalid = !aw_done && cyc >= aw_dly;
      s_axi_wvalid  = !w_done && cyc >= w_dly;
      aw_go = s_axi_awvalid && s_axi_awready;
      w_go  = s_axi_wvalid && s_axi_wready;
      @(posedge clk); #1;
      if (aw_go) begin aw_done = 1'b1; s_axi_awvalid = 1'b0; end
      if (w_go)  begin w_done = 1'b1; s_axi_wvalid = 1'b0; end
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    if (!(aw_done && w_done)) begin timeout("aw_w_handshake"); return; end
    n = 0;
    while (!s_axi_bvalid && n < 20) begin @(posedge clk); #1; n++; end
    if (!s_axi_bvalid) begin timeout("bvalid"); return; end
    resp = s_axi_bresp;
    repeat (stall) begin
      @(posedge clk); #1;
      if (!s_axi_bvalid || s_axi_bresp !== resp || s_axi_awready || s_axi_wready)
        stable_ok = 1'b0;
    end
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
  endtask

  // Holds arvalid during init and returns the edge count until init_done.
  task automatic release_reset(output int edges, output logic ar_low);
    int n;
    ar_low = 1'b1;
    @(negedge clk);
    s_axi_araddr  = 32'h3D;
    s_axi_arvalid = 1'b1;
    rst = 1'b0;
    n = 0;
    while (!init_done && n < 200) begin
      @(posedge clk); #1; n++;
      if (!init_done && s_axi_arready) ar_low = 1'b0;
    end
    s_axi_arvalid = 1'b0;
    edges = n;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } rd_vec_t;

  rd_vec_t     vecs [9];
  logic [31:0] data;
  logic [1:0]  resp;
  int          lat, edges, n;
  logic        hs_ok, stable_ok, ar_low;

  initial begin
    vecs[0] = '{32'h0000_003D, 32'h0000_0023, 2'b00};
    vecs[1] = '{32'h0000_0000, 32'h0000_0000, 2'b00};
    vecs[2] = '{32'h0000_003F, 32'h0000_0031, 2'b00};
    vecs[3] = '{32'h0000_0012, 32'h0000_0004, 2'b00};
    vecs[4] = '{32'h0000_002B, 32'h0000_000F, 2'b00};
    vecs[5] = '{32'h0000_0007, 32'h0000_0000, 2'b00};
    vecs[6] = '{32'h0000_0038, 32'h0000_0000, 2'b00};
    vecs[7] = '{32'h0000_0040, 32'h0000_0000, 2'b10};
    vecs[8] = '{32'h1000_0000, 32'h0000_0000, 2'b10};

    rst = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", s_axi_arready, 0);
    check("rst_awready", s_axi_awready, 0);
    check("rst_wready", s_axi_wready, 0);
    check("rst_rvalid", s_axi_rvalid, 0);
    check("rst_bvalid", s_axi_bvalid, 0);
    check("rst_rdata", s_axi_rdata, 0);
    check("rst_rresp", s_axi_rresp, 0);
    check("rst_bresp", s_axi_bresp, 0);
    check("rst_init_done", init_done, 0);

    release_reset(edges, ar_low);
    check("init_edges", edges, 64);
    check("init_arready_low", ar_low, 1);
    check("init_arready_high", s_axi_arready, 1);

    for (int i = 0; i < 9; i++) begin
      do_read(vecs[i].addr, 0, data, resp, lat, hs_ok, stable_ok);
      check($sformatf("vec%0d_rdata", i), data, vecs[i].exp_data);
      check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
      check($sformatf("vec%0d_latency", i), lat, 1);
      check($sformatf("vec%0d_handshake", i), hs_ok, 1);
    end

    for (int a = 0; a < 64; a++) begin
      do_read(a, 0, data, resp, lat, hs_ok, stable_ok);
      check($sformatf("sweep_%02h_rdata", a), data, (a >> 3) * (a & 7));
      check($sformatf("sweep_%02h_arready", a), hs_ok, 1);
    end

    // W leads AW by two cycles; only the low two bytes land.
    do_write(32'h09, 32'hDEAD_BEEF, 4'b0011, 2, 0, 0, resp, stable_ok);
    check("w09_bresp", resp, 2'b00);
    do_read(32'h09, 0, data, resp, lat, hs_ok, stable_ok);
    check("r09_after_write", data, 32'h0000_BEEF);

    // Same-cycle AW/W with no byte enables: OKAY, memory untouched.
    do_write(32'h2B, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0, resp, stable_ok);
    check("w2b_nostrb_bresp", resp, 2'b00);
    do_read(32'h2B, 0, data, resp, lat, hs_ok, stable_ok);
    check("r2b_unchanged", data, 32'd15);

    do_write(32'h100, 32'hFFFF_FFFF, 4'b1111, 0, 0, 0, resp, stable_ok);
    check("w100_bresp", resp, 2'b10);
    do_read(32'h00, 0, data, resp, lat, hs_ok, stable_ok);
    check("r00_after_miss", data, 32'd0);
    do_read(32'h3F, 0, data, resp, lat, hs_ok, stable_ok);
    check("r3f_after_miss", data, 32'd49);

    do_read(32'h3D, 5, data, resp, lat, hs_ok, stable_ok);
    check("rstall_rdata", data, 32'h23);
    check("rstall_stable", stable_ok, 1);
    check("rstall_handshake", hs_ok, 1);
    do_write(32'h20, 32'h1234_5678, 4'b1111, 0, 0, 5, resp, stable_ok);
    check("wstall_bresp", resp, 2'b00);
    check("wstall_stable", stable_ok, 1);
    do_read(32'h20, 0, data, resp, lat, hs_ok, stable_ok);
    check("r20_after_write", data, 32'h1234_5678);

    // AW leads W; then reset lands while the read response is pending.
    do_write(32'h12, 32'h0000_00FF, 4'b1111, 0, 3, 0, resp, stable_ok);
    check("w12_bresp", resp, 2'b00);
    @(negedge clk);
    s_axi_araddr = 32'h12;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin @(posedge clk); #1; n++; end
    check("r12_rvalid", s_axi_rvalid, 1);
    check("r12_rdata", s_axi_rdata, 32'hFF);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_rvalid", s_axi_rvalid, 0);
    check("midrst_rdata", s_axi_rdata, 0);
    check("midrst_init_done", init_done, 0);
    release_reset(edges, ar_low);
    check("reinit_edges", edges, 64);
    check("reinit_arready_low", ar_low, 1);
    do_read(32'h12, 0, data, resp, lat, hs_ok, stable_ok);
    check("r12_after_reinit", data, 32'd4);
    do_read(32'h09, 0, data, resp, lat, hs_ok, stable_ok);
    check("r09_after_reinit", data, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/axi_lite_timestable_slave.md
Name: axi_lite_timestable_slave

Overview:
AXI4-lite slave (responder) that owns the 0..7 x 0..7 times-table memory read by the times-table master. Holds 64 x 32-bit words and fills them with a*b after every reset. Serves single-beat AXI4-lite reads and writes. It is a synthesizable stand-in for the vendor block-memory IP, so benches and boards need no generated core.

Parameters:
DATA_W, 32, AXI data width; must be 32.
ADDR_W, 32, AXI address width.
IDX_W, 6, entry index width; depth is 2**IDX_W = 64; index = {a[2:0], b[2:0]}.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous active-high reset
s_axi_awaddr  input  ADDR_W  write address, word index (not byte address)
s_axi_awvalid  input  1  write address valid
s_axi_awready  output  1  write address ready
s_axi_wdata  input  DATA_W  write data
s_axi_wstrb  input  4  byte enables
s_axi_wvalid  input  1  write data valid
s_axi_wready  output  1  write data ready
s_axi_bresp  output  2  write response: 00 OKAY, 10 SLVERR
s_axi_bvalid  output  1  write response valid
s_axi_bready  input  1  write response ready
s_axi_araddr  input  ADDR_W  read address, word index
s_axi_arvalid  input  1  read address valid
s_axi_arready  output  1  read address ready
s_axi_rdata  output  DATA_W  read data
s_axi_rresp  output  2  read response: 00 OKAY, 10 SLVERR
s_axi_rvalid  output  1  read data valid
s_axi_rready  input  1  read data ready
init_done  output  1  table initialised; slave accepting transactions

Behaviour:
- Reset (rst=1 at an edge): all ready/valid outputs 0; rdata=0; rresp=00; bresp=00; init_done=0; both FSMs enter their idle state and the init FSM restarts at index 0. Reset mid-transaction aborts it, no response is issued, and all writes since the last init are lost.
- Init FSM: INIT then DONE.
  - In INIT, one entry is written per cycle: mem[i] = {26'b0, i[5:3]*i[2:0]} (6-bit product, zero-extended), i = 0..63.
  - The first INIT cycle is the first cycle with rst=0.
  - After the write of i=63, init_done=1 on the following edge. init_done is therefore high exactly 64 edges after rst deasserts.
  - While init_done=0: arready, awready and wready stay 0.
- Address decode: hit when addr[ADDR_W-1:IDX_W]==0, otherwise SLVERR. Index = addr[IDX_W-1:0].
- Read FSM: R_IDLE, then R_READ, then R_RESP.
  - R_IDLE: arready=init_done. On arvalid&&arready, latch the address and go to R_READ; arready=0.
  - R_READ (1 cycle): register rdata=mem[idx] (0 on a miss) and rresp (00 on a hit, 10 on a miss); set rvalid=1; go to R_RESP. rvalid therefore rises one edge after the AR handshake edge.
  - R_RESP: rvalid, rdata and rresp are held stable until rvalid&&rready. Then rvalid=0 and the FSM returns to R_IDLE; arready=1 again the following cycle.
- Write FSM: W_IDLE, then W_COMMIT, then W_RESP.
  - W_IDLE: awready=init_done and !aw_held; wready=init_done and !w_held.
  - AW and W are accepted independently, in either order or in the same cycle, and each is latched into a holding register.
  - When both are held, go to W_COMMIT.
  - W_COMMIT (1 cycle): on a hit, write mem[idx] byte-wise per wstrb (strb bit k enables byte k); on a miss, leave memory unchanged. Set bresp (00 on a hit, 10 on a miss), set bvalid=1, go to W_RESP.
  - W_RESP: bvalid and bresp held until bready; then clear both holding registers and return to W_IDLE.
- Read/write collision: if R_READ and W_COMMIT occur in the same cycle on the same index, the read returns the pre-write value.
- wstrb=0000 on a hit: OKAY response, memory unchanged.
- Only one outstanding read and one outstanding write; no IDs; no bursts.

Test Plan:
- Release rst and count cycles: init_done=1 exactly 64 edges after rst falls. Read addr 0x3D (a=7,b=5): rdata=0x00000023, rresp=00, rvalid one edge after the AR handshake.
- Read sweep of addr 0x00..0x3F: each rdata = addr[5:3]*addr[2:0] (addr 0x3F gives 49). arready is low from each handshake until the R handshake completes.
- Present W (0xDEADBEEF, wstrb=0011) 2 cycles before AW (addr 0x09): both handshakes complete, bresp=00. A subsequent read of 0x09 returns 0x0000BEEF.
- Read addr 0x40: rresp=10, rdata=0. Write addr 0x100 with data 0xFFFFFFFF: bresp=10. Reads of 0x00 and 0x3F still return 0 and 49.
- Hold rready=0 for 5 cycles after rvalid, and bready=0 for 5 cycles after bvalid: rvalid/rdata/rresp and bvalid/bresp stay constant; arready and awready stay 0.
- Assert arvalid during init: arready=0 until init_done. Write 0x12=0xFF, then pulse rst during R_RESP: rvalid=0 the next cycle. After re-init, a read of 0x12 returns 4 (the write is lost).
